// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: register-file sizes and the reorder-buffer entry layout,
// used by the ROB and by the rename/recovery logic.
package nand_cpu_pkg;

  localparam int NUM_D_REG = 16;
  localparam int NUM_S_REG = 8;
  localparam int D_ADDR_W  = $clog2(NUM_D_REG);
  localparam int S_ADDR_W  = $clog2(NUM_S_REG);

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                write_dst;
    logic [D_ADDR_W-1:0] prev_rw_addr;
    logic                write_s;
    logic [S_ADDR_W-1:0] prev_rs_addr;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement tracker: allocate at tail, complete by address, retire from head.
// Optional ROB_FLUSH_EN adds a flush port that discards every entry.
module reorder_buffer
  import nand_cpu_pkg::*;
#(
  parameter  int L = 8,
  localparam int P = $clog2(L)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  output logic [P-1:0]        alloc_rob_addr,
  input  logic                alloc_write_dst,
  input  logic [D_ADDR_W-1:0] alloc_prev_rw_addr,
  input  logic                alloc_write_s,
  input  logic [S_ADDR_W-1:0] alloc_prev_rs_addr,
  input  logic                complete_valid,
  input  logic [P-1:0]        complete_rob_addr,
  output logic                commit_valid,
  output logic [P-1:0]        commit_rob_addr,
  output logic                free_rw_valid,
  output logic [D_ADDR_W-1:0] free_rw_addr,
  output logic                free_rs_valid,
  output logic [S_ADDR_W-1:0] free_rs_addr
`ifdef ROB_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  localparam logic [P:0] FULL = (P+1)'(L);

  rob_entry       entries [L];
  logic [P-1:0]   head, tail;
  logic [P:0]     count;
  rob_entry       head_e;
  logic           kill;
  logic           do_alloc, do_complete, do_commit;

`ifdef ROB_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign head_e         = entries[head];
  assign alloc_ready    = (count != FULL);
  assign alloc_rob_addr = tail;

  assign commit_valid    = head_e.valid & head_e.done & ~kill;
  assign commit_rob_addr = head;
  assign free_rw_valid   = commit_valid & head_e.write_dst;
  assign free_rw_addr    = head_e.prev_rw_addr;
  assign free_rs_valid   = commit_valid & head_e.write_s;
  assign free_rs_addr    = head_e.prev_rs_addr;

  assign do_alloc    = alloc_valid & alloc_ready;
  assign do_commit   = commit_valid;
  // The tail slot is never valid while not full, but the explicit guard keeps
  // allocate-wins behaviour independent of that invariant.
  assign do_complete = complete_valid & entries[complete_rob_addr].valid &
                       ~(do_alloc & (complete_rob_addr == tail));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      entries <= '{default: '0};
    end else if (kill) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      entries <= '{default: '0};
    end else begin
      if (do_complete) entries[complete_rob_addr].done <= 1'b1;
      if (do_commit) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      if (do_alloc) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0,
                           write_dst: alloc_write_dst, prev_rw_addr: alloc_prev_rw_addr,
                           write_s: alloc_write_s, prev_rs_addr: alloc_prev_rs_addr};
        tail          <= tail + 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: program-order queue model, negedge monitor,
// directed scenarios followed by randomized traffic (flush exercised under ROB_FLUSH_EN).
module tb_reorder_buffer;
  import nand_cpu_pkg::*;

  localparam int L = 8;
  localparam int P = $clog2(L);

  logic                clk = 0;
  logic                n_rst = 0;
  logic                alloc_valid = 0;
  logic                alloc_ready;
  logic [P-1:0]        alloc_rob_addr;
  logic                alloc_write_dst = 0;
  logic [D_ADDR_W-1:0] alloc_prev_rw_addr = '0;
  logic                alloc_write_s = 0;
  logic [S_ADDR_W-1:0] alloc_prev_rs_addr = '0;
  logic                complete_valid = 0;
  logic [P-1:0]        complete_rob_addr = '0;
  logic                commit_valid;
  logic [P-1:0]        commit_rob_addr;
  logic                free_rw_valid;
  logic [D_ADDR_W-1:0] free_rw_addr;
  logic                free_rs_valid;
  logic [S_ADDR_W-1:0] free_rs_addr;
  logic                flush = 0;

  reorder_buffer #(.L(L)) dut (
    .clk(clk), .n_rst(n_rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_addr(alloc_rob_addr),
    .alloc_write_dst(alloc_write_dst), .alloc_prev_rw_addr(alloc_prev_rw_addr),
    .alloc_write_s(alloc_write_s), .alloc_prev_rs_addr(alloc_prev_rs_addr),
    .complete_valid(complete_valid), .complete_rob_addr(complete_rob_addr),
    .commit_valid(commit_valid), .commit_rob_addr(commit_rob_addr),
    .free_rw_valid(free_rw_valid), .free_rw_addr(free_rw_addr),
    .free_rs_valid(free_rs_valid), .free_rs_addr(free_rs_addr)
`ifdef ROB_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit wd;
    int prw;
    bit ws;
    int prs;
    bit done;
  } instr_t;

  instr_t mq[$];   // in-flight instructions, oldest first
  int     mtail = 0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: updates at each edge from the inputs the DUT sees.
  initial begin
    bit     com, al;
    instr_t n;
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst || flush) begin
        mq.delete();
        mtail = 0;
      end else begin
        com = (mq.size() > 0) && mq[0].done;
        al  = alloc_valid && (mq.size() < L);
        if (complete_valid)
          foreach (mq[i]) if (mq[i].addr == int'(complete_rob_addr)) mq[i].done = 1;
        if (com) void'(mq.pop_front());
        if (al) begin
          n.addr = mtail; n.wd = alloc_write_dst; n.prw = int'(alloc_prev_rw_addr);
          n.ws = alloc_write_s; n.prs = int'(alloc_prev_rs_addr); n.done = 0;
          mq.push_back(n);
          mtail = (mtail + 1) % L;
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the model every falling edge.
  initial begin
    bit ec;
    forever begin
      @(negedge clk);
      ec = (mq.size() > 0) && mq[0].done && !flush;
      chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < L));
      chk("alloc_rob_addr", 32'(alloc_rob_addr), 32'(mtail));
      chk("commit_valid", 32'(commit_valid), 32'(ec));
      if (ec) begin
        chk("commit_rob_addr", 32'(commit_rob_addr), 32'(mq[0].addr));
        chk("free_rw_valid", 32'(free_rw_valid), 32'(mq[0].wd));
        chk("free_rs_valid", 32'(free_rs_valid), 32'(mq[0].ws));
        if (mq[0].wd) chk("free_rw_addr", 32'(free_rw_addr), 32'(mq[0].prw));
        if (mq[0].ws) chk("free_rs_addr", 32'(free_rs_addr), 32'(mq[0].prs));
      end else begin
        chk("free_rw_idle", 32'(free_rw_valid), 32'd0);
        chk("free_rs_idle", 32'(free_rs_valid), 32'd0);
      end
    end
  end

  task automatic cyc(input bit av, input bit wd, input int prw, input bit ws, input int prs,
                     input bit cv, input int ca, input bit fl);
    alloc_valid = av; alloc_write_dst = wd; alloc_prev_rw_addr = D_ADDR_W'(prw);
    alloc_write_s = ws; alloc_prev_rs_addr = S_ADDR_W'(prs);
    complete_valid = cv; complete_rob_addr = P'(ca); flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    n_rst = 0;
    idle(2);
    n_rst = 1;
    idle(1);
  endtask

  initial begin
    int ca;
    do_reset();
    chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("reset_alloc_addr", 32'(alloc_rob_addr), 32'd0);
    chk("reset_commit_valid", 32'(commit_valid), 32'd0);
    chk("reset_commit_addr", 32'(commit_rob_addr), 32'd0);

    // Three allocations, nothing completes.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("three_alloc_next_addr", 32'(alloc_rob_addr), 32'd3);

    // Out-of-order completion, in-order commit.
    do_reset();
    cyc(1, 1, 5, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Fill, then allocate while the head commits; then wrap.
    do_reset();
    for (int i = 0; i < L; i++) cyc(1, i[0], i, ~i[0], i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 9, 0, 0, 0, 0, 0);
    for (int i = 1; i < L; i++) cyc(0, 0, 0, 0, 0, 1, i, 0);
    idle(L + 2);

    // Completion to an invalid entry is dropped.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 6, 0);
    for (int i = 2; i <= 6; i++) cyc(1, 1, i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, i, 0);
    idle(8);
    cyc(0, 0, 0, 0, 0, 1, 6, 0);
    idle(2);

    // Allocate, complete and commit on three distinct entries at once.
    do_reset();
    cyc(1, 1, 3, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 7, 1, 1, 1, 1, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 2, 0);
    idle(2);

`ifdef ROB_FLUSH_EN
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 1, i, 1, i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    alloc_valid = 0; complete_valid = 0; flush = 1;
    #4;
    chk("flush_commit_valid", 32'(commit_valid), 32'd0);
    @(posedge clk); #1;
    flush = 0;
    #1;
    chk("flush_alloc_addr", 32'(alloc_rob_addr), 32'd0);
    chk("flush_alloc_ready", 32'(alloc_ready), 32'd1);
    idle(2);
`endif

    // Reset mid-operation with pending completed entries.
    for (int i = 0; i < 4; i++) cyc(1, 1, i, 1, i, 1, 0, 0);
    n_rst = 0;
    #1;
    chk("midrst_commit_valid", 32'(commit_valid), 32'd0);
    chk("midrst_alloc_addr", 32'(alloc_rob_addr), 32'd0);
    idle(1);
    n_rst = 1;
    idle(1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) != 0 && mq.size() > 0)
        ca = mq[$urandom_range(0, mq.size() - 1)].addr;
      else
        ca = $urandom_range(0, L - 1);
      if ($urandom_range(0, 299) == 0) begin
        n_rst = 0;
        idle(1);
        n_rst = 1;
      end
      cyc($urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, NUM_D_REG - 1),
          1'($urandom), $urandom_range(0, NUM_S_REG - 1),
          $urandom_range(0, 1), ca,
`ifdef ROB_FLUSH_EN
          $urandom_range(0, 99) == 0
`else
          1'b0
`endif
          );
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
